kw_arb_stream_mux: RTL

KW_ARB_STREAM_MUX -- requirements
Module: KW_arb_stream_mux

---
 rtl/kw_arb_stream_mux_if.sv | 30 +++
 rtl/kw_arb_stream_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/kw_arb_stream_mux_if.sv
// Stream bundle for kw_arb_stream_mux: N source channels merged onto one output
// channel, plus the arbiter status lines.
interface kw_arb_stream_mux_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   grant;
  logic           busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id, grant, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id, grant, busy
  );
endinterface

// File: rtl/kw_arb_stream_mux.sv
// Packet-locked round-robin stream multiplexer: N sources onto one stream.
// Define KW_ARB_STREAM_MUX_OREG_EN to add a registered 2-entry skid buffer on the output.
module kw_arb_stream_mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  kw_arb_stream_mux_if.slave   bus
);
  localparam int IDW = $clog2(N);
  localparam int DW  = IDW + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [N-1:0]   grant_reg;

  logic [DW-1:0]  rr_dist [N];
  logic [N-1:0]   rr_grant;
  logic [N-1:0]   grant;
  logic           sel_valid;
  logic           sel_last;
  logic [W-1:0]   sel_data;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] ptr_next;
  logic           accept;
  logic           take;
  logic           take_last;

  // A source wins when it is valid and no other valid source sits closer to ptr.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_src
      logic [N-1:0] beaten;
      assign rr_dist[gi] = (IDW'(gi) >= ptr_reg) ? DW'(gi) - {1'b0, ptr_reg}
                                                 : DW'(gi + N) - {1'b0, ptr_reg};
      for (genvar gj = 0; gj < N; gj++) begin : g_cmp
        if (gj == gi) begin : g_self
          assign beaten[gj] = 1'b0;
        end else begin : g_other
          assign beaten[gj] = bus.in_valid[gj] & (rr_dist[gj] < rr_dist[gi]);
        end
      end
      assign rr_grant[gi] = bus.in_valid[gi] & ~|beaten;
    end
  endgenerate

  assign grant = !reset_n ? '0 : ((state_reg == LOCK) ? grant_reg : rr_grant);

  always_comb begin
    sel_data = '0;
    sel_id   = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (bus.in_data[i*W +: W] & {W{grant[i]}});
      if (grant[i]) sel_id = sel_id | IDW'(i);
    end
  end

  assign sel_valid = |(grant & bus.in_valid);
  assign sel_last  = |(grant & bus.in_last);
  assign take      = sel_valid & accept;
  assign take_last = take & sel_last;
  assign ptr_next  = (sel_id == IDW'(N - 1)) ? '0 : sel_id + IDW'(1);

  assign bus.in_ready = grant & {N{accept}};
  assign bus.grant    = grant;
  assign bus.busy     = (state_reg == LOCK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid && !take_last) begin
            state_reg <= LOCK;
            grant_reg <= grant;
          end
        end
        LOCK: begin
          if (take_last) begin
            state_reg <= IDLE;
            grant_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (take_last) ptr_reg <= ptr_next;
    end
  end

`ifdef KW_ARB_STREAM_MUX_OREG_EN
  logic           out_valid_reg;
  logic [W-1:0]   out_data_reg;
  logic           out_last_reg;
  logic [IDW-1:0] out_id_reg;
  logic           skid_valid_reg;
  logic [W-1:0]   skid_data_reg;
  logic           skid_last_reg;
  logic [IDW-1:0] skid_id_reg;

  // Sources see only the registered "skid empty" flag, never out_ready.
  assign accept = ~skid_valid_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_id_reg     <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_id_reg    <= '0;
    end else if (!skid_valid_reg) begin
      if (out_valid_reg && !bus.out_ready) begin
        if (take) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= sel_data;
          skid_last_reg  <= sel_last;
          skid_id_reg    <= sel_id;
        end
      end else begin
        out_valid_reg <= take;
        if (take) begin
          out_data_reg <= sel_data;
          out_last_reg <= sel_last;
          out_id_reg   <= sel_id;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_reg  <= 1'b1;
      out_data_reg   <= skid_data_reg;
      out_last_reg   <= skid_last_reg;
      out_id_reg     <= skid_id_reg;
      skid_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_id    = out_id_reg;
`else
  assign accept        = bus.out_ready;
  assign bus.out_valid = sel_valid;
  assign bus.out_data  = sel_data;
  assign bus.out_last  = sel_last;
  assign bus.out_id    = sel_id;
`endif
endmodule
